// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - multi-channel clock-enable generator with reset stretcher
module clk_en_gen #(
    parameter int NUM_CH   = 3,
    parameter int ACC_W    = 24,
    parameter int RST_HOLD = 10,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic              cfg_mode_i,
    input  logic              cfg_en_i,
    input  logic [ACC_W-1:0]  cfg_inc_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] phase_o,
    output logic              rst_out_o
);

    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] phase_q, phase_d;
    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_d [NUM_CH];
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];

    logic [7:0] hold_q, hold_d;
    logic       rst_out_q, rst_out_d;

    logic [ACC_W-1:0] deff_v;
    logic [ACC_W:0]   sum_v;

    always_comb begin
        mode_d  = mode_q;
        en_d    = en_q;
        tick_d  = tick_q;
        phase_d = phase_q;
        deff_v  = '0;
        sum_v   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            inc_d[i] = inc_q[i];
            acc_d[i] = acc_q[i];
            // An out-of-range cfg_ch never matches any channel, so the write is dropped.
            if (cfg_we_i && (cfg_ch_i == CH_W'(i))) begin
                mode_d[i]  = cfg_mode_i;
                en_d[i]    = cfg_en_i;
                inc_d[i]   = cfg_inc_i;
                acc_d[i]   = '0;
                tick_d[i]  = 1'b0;
                phase_d[i] = 1'b0;
            end else if (!en_q[i]) begin
                acc_d[i]  = '0;
                tick_d[i] = 1'b0;
            end else if (!mode_q[i]) begin
                deff_v = (inc_q[i] == '0) ? ACC_W'(1) : inc_q[i];
                if (acc_q[i] >= deff_v - ACC_W'(1)) begin
                    acc_d[i]   = '0;
                    tick_d[i]  = 1'b1;
                    phase_d[i] = ~phase_q[i];
                end else begin
                    acc_d[i]  = acc_q[i] + ACC_W'(1);
                    tick_d[i] = 1'b0;
                end
            end else begin
                sum_v      = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
                acc_d[i]   = sum_v[ACC_W-1:0];
                tick_d[i]  = sum_v[ACC_W];
                phase_d[i] = phase_q[i] ^ sum_v[ACC_W];
            end
        end
    end

    // Stretcher counts down after reset falls; rst_out drops on the edge that finds it at zero.
    always_comb begin
        hold_d    = hold_q;
        rst_out_d = rst_out_q;
        if (hold_q != 8'd0) begin
            hold_d    = hold_q - 8'd1;
            rst_out_d = 1'b1;
        end else begin
            rst_out_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mode_q    <= '0;
            en_q      <= '0;
            tick_q    <= '0;
            phase_q   <= '0;
            hold_q    <= 8'(RST_HOLD);
            rst_out_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                inc_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            mode_q    <= mode_d;
            en_q      <= en_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            rst_out_q <= rst_out_d;
            for (int i = 0; i < NUM_CH; i++) begin
                inc_q[i] <= inc_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign tick_o    = tick_q;
    assign phase_o   = phase_q;
    assign rst_out_o = rst_out_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - self-checking bench for clk_en_gen against a rate-based reference model
module tb_clk_en_gen;

    localparam int NUM_CH   = 3;
    localparam int ACC_W    = 4;
    localparam int RST_HOLD = 10;
    localparam int CH_W     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic              cfg_mode = 1'b0;
    logic              cfg_en = 1'b0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] phase;
    logic              rst_out;

    int checks = 0;
    int errors = 0;

    int     m_mode [NUM_CH];
    int     m_en   [NUM_CH];
    int     m_inc  [NUM_CH];
    longint m_k    [NUM_CH];
    int     m_since;
    bit     m_in_rst;

    clk_en_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .RST_HOLD(RST_HOLD)) dut (
        .clock_i   (clk),
        .reset_i   (reset),
        .cfg_we_i  (cfg_we),
        .cfg_ch_i  (cfg_ch),
        .cfg_mode_i(cfg_mode),
        .cfg_en_i  (cfg_en),
        .cfg_inc_i (cfg_inc),
        .tick_o    (tick),
        .phase_o   (phase),
        .rst_out_o (rst_out)
    );

    always #5 clk = ~clk;

    // Number of carries out of the accumulator after k edges is floor(k*inc / 2^ACC_W).
    function automatic longint frac_count(int c, longint k);
        return (k * m_inc[c]) / (longint'(1) << ACC_W);
    endfunction

    function automatic int deff(int c);
        return (m_inc[c] == 0) ? 1 : m_inc[c];
    endfunction

    function automatic bit exp_tick(int c);
        if (m_en[c] == 0 || m_k[c] == 0) return 1'b0;
        if (m_mode[c] == 0) return (m_k[c] % deff(c)) == 0;
        return frac_count(c, m_k[c]) != frac_count(c, m_k[c] - 1);
    endfunction

    function automatic bit exp_phase(int c);
        if (m_en[c] == 0) return 1'b0;
        if (m_mode[c] == 0) return ((m_k[c] / deff(c)) % 2) == 1;
        return (frac_count(c, m_k[c]) % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit we, input int ch, input bit mode, input bit en, input int inc);
        reset    = rst;
        cfg_we   = we;
        cfg_ch   = CH_W'(ch);
        cfg_mode = mode;
        cfg_en   = en;
        cfg_inc  = ACC_W'(inc);
        @(posedge clk);
        if (rst) begin
            m_in_rst = 1'b1;
            m_since  = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_en[c] = 0; m_mode[c] = 0; m_inc[c] = 0; m_k[c] = 0;
            end
        end else begin
            m_in_rst = 1'b0;
            m_since++;
            for (int c = 0; c < NUM_CH; c++) m_k[c]++;
            if (we && ch < NUM_CH) begin
                m_mode[ch] = int'(mode); m_en[ch] = int'(en); m_inc[ch] = inc; m_k[ch] = 0;
            end
        end
        #1;
        cfg_we = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("tick%0d", c), tick[c], exp_tick(c));
            check($sformatf("phase%0d", c), phase[c], exp_phase(c));
        end
        check("rst_out", rst_out, m_in_rst || (m_since <= RST_HOLD));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input bit mode, input bit en, input int inc);
        step(0, 1, ch, mode, en, inc);
    endtask

    initial begin
        int cnt;
        int prev;

        // Power-on reset held three cycles, then the stretch window.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        idle(12);

        // Integer divide by 3 on ch0.
        wr(0, 0, 1, 3);
        idle(12);

        // Fractional inc=6 on ch1: 6 ticks per 16 cycles, never back to back.
        wr(1, 1, 1, 6);
        cnt = 0; prev = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1);
            cnt += int'(tick[1]);
            check("frac_no_double", logic'(prev == 1 && tick[1] == 1'b1), 1'b0);
            prev = int'(tick[1]);
        end
        check("frac_count16", logic'(cnt == 6), 1'b1);
        idle(16);

        // ch2 with divisor 0 and 1, then disabled.
        wr(2, 0, 1, 0);
        idle(5);
        wr(2, 0, 1, 1);
        idle(5);
        wr(2, 0, 0, 1);
        idle(3);

        // Out-of-range channel write, then write coincident with reset.
        wr(3, 1, 1, 7);
        idle(3);
        step(1, 1, 2, 0, 1, 1);
        idle(13);

        // Reset in the middle of a divide-by-5 run.
        wr(0, 0, 1, 5);
        idle(3);
        step(1, 0, 0, 0, 0, 0);
        idle(12);

        // Near-full-rate fractional increment.
        wr(1, 1, 1, 15);
        idle(20);

        // Randomized writes and occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(63) == 0)
                step(1, 0, 0, 0, 0, 0);
            else if ($urandom_range(11) == 0)
                wr(int'($urandom_range(3)), 1'($urandom), 1'($urandom_range(7) != 0),
                   int'($urandom_range(15)));
            else
                idle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
